spi_reg_bank: RTL and testbench
===============================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM channels; the address map spans 6*NUM_CH bytes.
REQ-002 SHALL have parameter ADDR_W, default 8, width of the byte address pointer.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port _RST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port _CS, input, 1 bit: SPI chip select, active-low, already synchronized to CLK.
REQ-006 SHALL have port rx_byte, input, 8 bits: byte received from the SPI shift register.
REQ-007 SHALL have port rx_valid, input, 1 bit: one-CLK pulse marking rx_byte as valid.
REQ-008 SHALL have port switch_vals, output, 16*NUM_CH bits: the per-channel PWM switch-point values, channel n at bits [16n+15:16n].
REQ-009 SHALL have port count_vals, output, 16*NUM_CH bits: the per-channel PWM period (top) values, same packing as switch_vals.
REQ-010 SHALL have port prescale_vals, output, 16*NUM_CH bits: the per-channel prescaler values, same packing as switch_vals.
REQ-011 SHALL have port update, output, NUM_CH bits: one-CLK pulse per channel when any of that channel's registers commits.
REQ-012 SHALL have port tx_byte, output, 8 bits: the readback byte at the current address pointer.

Function
REQ-013 SHALL implement the FSM states IDLE, ADDR and DATA.
REQ-014 SHALL enter ADDR on any CLK edge that samples _CS low while in IDLE.
REQ-015 SHALL, in ADDR, load the first rx_valid byte into the address pointer and move to DATA.
REQ-016 SHALL return to IDLE from any state within 1 CLK of _CS sampled high, discarding any staged byte.
REQ-017 SHALL use this address map for channel n at base 6n: +0 switch hi, +1 switch lo, +2 count hi, +3 count lo, +4 prescaler hi, +5 prescaler lo.
REQ-018 SHALL, in DATA on each rx_valid, write the byte at the pointer and then increment the pointer modulo 2^ADDR_W.
REQ-019 SHALL place a hi-byte write only into a per-transaction staging register; the output is unchanged.
REQ-020 SHALL, on a lo-byte write, commit {staged hi, lo} to the output register and pulse update[n] the following CLK.
REQ-021 SHALL, when a lo byte is written with no hi byte for that register staged in the same transaction, commit {current hi, lo}.
REQ-022 SHALL ignore writes at addresses >= 6*NUM_CH (no change, no update pulse) while the pointer still increments; a wrapped pointer writes again from address 0.
REQ-023 SHALL ignore rx_valid while in IDLE.
REQ-024 SHALL drive tx_byte combinationally from the register byte at the pointer, or 0x00 when the pointer is out of range.

Reset
REQ-025 SHALL, while _RST is low and regardless of CLK, set the FSM to IDLE and the pointer, staging register, all value outputs, update and tx_byte to 0.
REQ-026 SHALL, on reset asserted mid-transaction, abort the transaction with no partial commit; the next transaction needs a fresh _CS assertion while _CS is low.

Configuration
REQ-027 SHALL gate readback with macro SPI_REG_READBACK_EN: when defined, tx_byte behaves per REQ-024; when undefined, tx_byte is constant 0x00 and its readback mux is not synthesized.

Verification
REQ-028 SHALL cover: _CS low, bytes 0x06, 0x12, 0x34 -> switch_vals[31:16]=0x1234, update=4'b0010 for 1 CLK, all other outputs unchanged.
REQ-029 SHALL cover: _CS low, address 0x00 then 6 bytes 02 A5 04 7F 00 04 -> ch0 switch=0x02A5, count=0x047F, prescaler=0x0004, three update[0] pulses.
REQ-030 SHALL cover: prescaler0=0x0004 set, then a new transaction with 0x05, 0x00 -> prescaler0=0x0000 (hi from current value).
REQ-031 SHALL cover: address 0x16, bytes 0xAB, 0xCD, then _CS high -> prescaler3=0xABCD; a further transaction at address 0x18 with 0xFF leaves every output unchanged.
REQ-032 SHALL cover: address 0x02, byte 0x55, then _CS high -> count0 unchanged; a new transaction at address 0x03 with 0x66 commits {old hi, 0x66}.
REQ-033 SHALL cover: _RST pulsed low between the hi and lo bytes -> all outputs 0 immediately; later lo-only writes commit {0x00, lo}.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI register bank: byte-addressed PWM switch/count/prescale registers, hi bytes staged until the lo byte commits.
// Readback of the addressed byte on tx_byte is built only when SPI_REG_READBACK_EN is defined.
//   state | meaning
//   IDLE  | chip select high, or low but not yet re-armed after reset
//   ADDR  | waiting for the address byte
//   DATA  | writing bytes at the auto-incrementing pointer
module spi_reg_bank #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic                  CLK,
    input  logic                  _RST,
    input  logic                  _CS,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [16*NUM_CH-1:0]  switch_vals,
    output logic [16*NUM_CH-1:0]  count_vals,
    output logic [16*NUM_CH-1:0]  prescale_vals,
    output logic [NUM_CH-1:0]     update,
    output logic [7:0]            tx_byte
);
    localparam int NUM_REGS  = 3 * NUM_CH;
    localparam int NUM_BYTES = 6 * NUM_CH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [15:0]         regs [NUM_REGS];
    logic [7:0]          stage_byte;
    logic                stage_valid;
    logic [31:0]         stage_idx;
    logic                cs_armed;

    logic [31:0]         ptr_ext;
    logic [31:0]         reg_idx;
    logic                in_range;
    logic [NUM_CH-1:0]   ch_hit;
    logic [7:0]          commit_hi;

    // Each 16-bit register occupies an even/odd byte pair, so the register index is ptr/2.
    assign ptr_ext  = 32'(ptr);
    assign reg_idx  = ptr_ext >> 1;
    assign in_range = ptr_ext < 32'(NUM_BYTES);

    always_comb begin
        ch_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (reg_idx == 32'(3 * c + k)) ch_hit[c] = 1'b1;
            end
        end
    end

    always_comb begin
        commit_hi = 8'h00;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_idx == 32'(r)) commit_hi = regs[r][15:8];
        end
        if (stage_valid && (stage_idx == reg_idx)) commit_hi = stage_byte;
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state       <= IDLE;
            ptr         <= '0;
            stage_byte  <= 8'h00;
            stage_valid <= 1'b0;
            stage_idx   <= '0;
            cs_armed    <= 1'b0;
            update      <= '0;
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= 16'h0000;
        end else begin
            update <= '0;
            if (_CS) begin
                state       <= IDLE;
                stage_valid <= 1'b0;
                cs_armed    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // After a reset, _CS must be seen high before a new transaction starts.
                        if (cs_armed) begin
                            state       <= ADDR;
                            stage_valid <= 1'b0;
                        end
                    end
                    ADDR: begin
                        if (rx_valid) begin
                            ptr   <= ADDR_W'(rx_byte);
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
                            ptr <= ptr + ADDR_W'(1);
                            if (in_range) begin
                                if (!ptr[0]) begin
                                    stage_byte  <= rx_byte;
                                    stage_valid <= 1'b1;
                                    stage_idx   <= reg_idx;
                                end else begin
                                    for (int r = 0; r < NUM_REGS; r++) begin
                                        if (reg_idx == 32'(r)) regs[r] <= {commit_hi, rx_byte};
                                    end
                                    update <= ch_hit;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
        assign switch_vals[16*c +: 16]   = regs[3*c];
        assign count_vals[16*c +: 16]    = regs[3*c + 1];
        assign prescale_vals[16*c +: 16] = regs[3*c + 2];
    end

`ifdef SPI_REG_READBACK_EN
    logic [15:0] rd_word;

    always_comb begin
        rd_word = 16'h0000;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_idx == 32'(r)) rd_word = regs[r];
        end
    end

    assign tx_byte = !in_range ? 8'h00 : (ptr[0] ? rd_word[7:0] : rd_word[15:8]);
`else
    assign tx_byte = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: expected commits are queued as bytes are driven and checked on each update pulse.
module tb_spi_reg_bank;
    logic        CLK;
    logic        _RST;
    logic        _CS;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [63:0] switch_vals;
    logic [63:0] count_vals;
    logic [63:0] prescale_vals;
    logic [3:0]  update;
    logic [7:0]  tx_byte;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  upd;
        logic [63:0] sw;
        logic [63:0] cnt;
        logic [63:0] pre;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] e_sw  = '0;
    logic [63:0] e_cnt = '0;
    logic [63:0] e_pre = '0;

    spi_reg_bank #(.NUM_CH(4), .ADDR_W(8)) dut (
        .CLK           (CLK),
        ._RST          (_RST),
        ._CS           (_CS),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .switch_vals   (switch_vals),
        .count_vals    (count_vals),
        .prescale_vals (prescale_vals),
        .update        (update),
        .tx_byte       (tx_byte)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard consumer: every update pulse must match the next queued commit.
    always @(negedge CLK) begin
        if (_RST === 1'b1 && update !== 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update got=%b want=none", update);
            end else begin
                mon_e = sb.pop_front();
                if (update !== mon_e.upd || switch_vals !== mon_e.sw ||
                    count_vals !== mon_e.cnt || prescale_vals !== mon_e.pre) begin
                    errors++;
                    $display("FAIL commit got upd=%b sw=%h cnt=%h pre=%h want upd=%b sw=%h cnt=%h pre=%h",
                             update, switch_vals, count_vals, prescale_vals,
                             mon_e.upd, mon_e.sw, mon_e.cnt, mon_e.pre);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rb(input logic [7:0] v);
`ifdef SPI_REG_READBACK_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic push_exp(input logic [3:0] m);
        exp_t e;
        e.upd = m;
        e.sw  = e_sw;
        e.cnt = e_cnt;
        e.pre = e_pre;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge CLK);
        _CS = 1'b0;
    endtask

    task automatic cs_high();
        @(negedge CLK);
        _CS = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        _RST = 1'b0; _CS = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge CLK);
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== 192'h0) begin
            errors++;
            $display("FAIL reset_values got sw=%h cnt=%h pre=%h want all 0", switch_vals, count_vals, prescale_vals);
        end
        checks++;
        if (update !== 4'b0000) begin errors++; $display("FAIL reset_update got=%b want=0000", update); end
        checks++;
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx got=%h want=00", tx_byte); end
        _RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_idle_ignore();
        send_byte(8'h06); send_byte(8'h12); send_byte(8'h34);
        repeat (2) @(negedge CLK);
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre}) begin
            errors++;
            $display("FAIL idle_ignore got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
    endtask

    task automatic test_single_write();
        cs_low();
        send_byte(8'h06);
        send_byte(8'h12);
        e_sw[31:16] = 16'h1234;
        push_exp(4'b0010);
        send_byte(8'h34);
        cs_high();
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre}) begin
            errors++;
            $display("FAIL single_write got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL single_write_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_burst();
        cs_low();
        send_byte(8'h00);
        send_byte(8'h02);
        checks++;
        if (switch_vals !== e_sw) begin
            errors++;
            $display("FAIL hi_staged_only got=%h want=%h", switch_vals, e_sw);
        end
        e_sw[15:0] = 16'h02A5;  push_exp(4'b0001); send_byte(8'hA5);
        send_byte(8'h04);
        e_cnt[15:0] = 16'h047F; push_exp(4'b0001); send_byte(8'h7F);
        send_byte(8'h00);
        e_pre[15:0] = 16'h0004; push_exp(4'b0001); send_byte(8'h04);
        cs_high();
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre}) begin
            errors++;
            $display("FAIL burst got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL burst_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_lo_only();
        cs_low();
        send_byte(8'h05);
        e_pre[15:0] = 16'h0000; push_exp(4'b0001);
        send_byte(8'h00);
        cs_high();
        checks++;
        if (prescale_vals !== e_pre || sb.size() != 0) begin
            errors++;
            $display("FAIL lo_only got pre=%h pending=%0d want pre=%h pending=0", prescale_vals, sb.size(), e_pre);
        end
    endtask

    task automatic test_out_of_range();
        cs_low();
        send_byte(8'h16);
        send_byte(8'hAB);
        e_pre[63:48] = 16'hABCD; push_exp(4'b1000);
        send_byte(8'hCD);
        cs_high();
        cs_low();
        send_byte(8'h18);
        send_byte(8'hFF);
        cs_high();
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre} || sb.size() != 0) begin
            errors++;
            $display("FAIL out_of_range got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
        // pointer at 0xFF: ignored write, then wraps to address 0
        cs_low();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h11);
        e_sw[15:0] = 16'h1122; push_exp(4'b0001);
        send_byte(8'h22);
        cs_high();
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre} || sb.size() != 0) begin
            errors++;
            $display("FAIL ptr_wrap got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
    endtask

    task automatic test_abort();
        cs_low();
        send_byte(8'h02);
        send_byte(8'h55);
        cs_high();
        checks++;
        if (count_vals !== e_cnt) begin
            errors++;
            $display("FAIL abort_no_commit got=%h want=%h", count_vals, e_cnt);
        end
        cs_low();
        send_byte(8'h03);
        e_cnt[15:0] = 16'h0466; push_exp(4'b0001);
        send_byte(8'h66);
        cs_high();
        checks++;
        if (count_vals !== e_cnt || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_stage_dropped got=%h want=%h", count_vals, e_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cs_low();
        send_byte(8'h0C);
        e_sw[47:32]  = 16'hDEAD; push_exp(4'b0100);
        e_cnt[47:32] = 16'hBEEF; push_exp(4'b0100);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            rx_byte  = bytes[i];
            rx_valid = 1'b1;
        end
        @(negedge CLK);
        rx_valid = 1'b0;
        cs_high();
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre} || sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
    endtask

    task automatic test_readback();
        cs_low();
        send_byte(8'h0C);
        checks++;
        if (tx_byte !== rb(8'hDE)) begin errors++; $display("FAIL readback_hi got=%h want=%h", tx_byte, rb(8'hDE)); end
        cs_high();
        cs_low();
        send_byte(8'h0F);
        checks++;
        if (tx_byte !== rb(8'hEF)) begin errors++; $display("FAIL readback_lo got=%h want=%h", tx_byte, rb(8'hEF)); end
        cs_high();
        cs_low();
        send_byte(8'h18);
        checks++;
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL readback_oor got=%h want=00", tx_byte); end
        cs_high();
    endtask

    task automatic test_reset_mid();
        cs_low();
        send_byte(8'h00);
        send_byte(8'h99);
        #2 _RST = 1'b0;
        #1;
        e_sw = '0; e_cnt = '0; e_pre = '0;
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== 192'h0 || update !== 4'b0000 || tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got sw=%h cnt=%h pre=%h upd=%b tx=%h want all 0",
                     switch_vals, count_vals, prescale_vals, update, tx_byte);
        end
        @(negedge CLK);
        _RST = 1'b1;
        // _CS still low: bytes must be ignored until _CS is re-asserted
        send_byte(8'h01);
        send_byte(8'h88);
        repeat (2) @(negedge CLK);
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== 192'h0) begin
            errors++;
            $display("FAIL reset_rearm got sw=%h cnt=%h pre=%h want all 0", switch_vals, count_vals, prescale_vals);
        end
        cs_high();
        cs_low();
        send_byte(8'h01);
        e_sw[15:0] = 16'h0077; push_exp(4'b0001);
        send_byte(8'h77);
        cs_high();
        cs_low();
        send_byte(8'h17);
        e_pre[63:48] = 16'h0042; push_exp(4'b1000);
        send_byte(8'h42);
        cs_high();
        checks++;
        if ({switch_vals, count_vals, prescale_vals} !== {e_sw, e_cnt, e_pre} || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_lo_only got sw=%h cnt=%h pre=%h want sw=%h cnt=%h pre=%h",
                     switch_vals, count_vals, prescale_vals, e_sw, e_cnt, e_pre);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_single_write();
        test_burst();
        test_lo_only();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        test_readback();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
